icache_dm: RTL and testbench

//  Direct-mapped, read-only instruction cache between the fetch stage and the instruction memory port.

---
 rtl/icache_pkg.sv | 29 ++
 rtl/icache_dm_if.sv | 25 ++
 rtl/icache_data_ram.sv | 32 +++
 rtl/icache_dm.sv | 141 ++++++++++++++
 tb/tb_icache_dm.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// icache_pkg: geometry, FSM state encoding and address layout shared by the icache_dm slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// The cache geometry is set here in one place: NUM_SETS lines of LINE_WORDS 32-bit words.
package icache_pkg;

  localparam int unsigned NUM_SETS   = 64;  // power of 2, >= 2
  localparam int unsigned LINE_WORDS = 4;   // power of 2, >= 2

  localparam int unsigned OFF_W = $clog2(LINE_WORDS);
  localparam int unsigned IDX_W = $clog2(NUM_SETS);
  localparam int unsigned TAG_W = 30 - OFF_W - IDX_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MISS_REQ,
    S_FILL,
    S_RESP
  } icache_state_e;

  // Byte address viewed as tag / set index / word offset / byte-in-word.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    logic [OFF_W-1:0] off;
    logic [1:0]       byte_off;
  } icache_addr_t;

endpackage

// File: rtl/icache_dm_if.sv
// Fetch-side and memory-side bundles of the instruction cache.
// Latency: n/a (wiring only).
// Backpressure: fetch keeps one request outstanding; memory side holds req until gnt.
// icache_fetch_if: icache_en_i/icache_addr_i (fetch -> cache), icache_rdata_o/icache_rvalid_o (cache -> fetch).
// icache_mem_if:   mem_req_o/mem_addr_o (cache -> mem), mem_gnt_i/mem_rvalid_i/mem_rdata_i (mem -> cache).
interface icache_fetch_if;
  logic        icache_en_i;
  logic [31:0] icache_addr_i;
  logic [31:0] icache_rdata_o;
  logic        icache_rvalid_o;

  modport master (output icache_en_i, icache_addr_i, input icache_rdata_o, icache_rvalid_o);
  modport slave  (input icache_en_i, icache_addr_i, output icache_rdata_o, icache_rvalid_o);
endinterface

interface icache_mem_if;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  modport master (output mem_req_o, mem_addr_o, input mem_gnt_i, mem_rvalid_i, mem_rdata_i);
  modport slave  (input mem_req_o, mem_addr_o, output mem_gnt_i, mem_rvalid_i, mem_rdata_i);
endinterface

// File: rtl/icache_data_ram.sv
// icache_data_ram: 1R1W word array for cache line data, address = {set index, word offset}.
// Latency: read data appears the cycle after re; write takes effect at the clock edge.
// Backpressure: none; both ports accept every cycle.
// Ports: clk, rst_n (clears only the read register), we/waddr/wdata, re/raddr, rdata.
module icache_data_ram
  import icache_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   we,
  input  logic [IDX_W+OFF_W-1:0] waddr,
  input  logic [31:0]            wdata,
  input  logic                   re,
  input  logic [IDX_W+OFF_W-1:0] raddr,
  output logic [31:0]            rdata
);

  localparam int unsigned DEPTH = NUM_SETS * LINE_WORDS;

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Read register holds its value between reads so the hit word stays stable.
  always_ff @(posedge clk) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/icache_dm.sv
// icache_dm: direct-mapped read-only instruction cache between fetch and the instruction memory port.
// Latency: hit -> rvalid 1 cycle after en; miss -> request, grant wait, LINE_WORDS beats, then response.
// Backpressure: one fetch outstanding, en ignored outside IDLE; mem_req_o held until mem_gnt_i.
// Ports: clk, rst_n (sync, active-low), flush_i, inval_i, fetch (icache_fetch_if.slave), mem (icache_mem_if.master).
// Optional macro ICACHE_PERF_CNT_EN adds saturating hit_cnt_o / miss_cnt_o outputs.
module icache_dm
  import icache_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          inval_i,
  icache_fetch_if.slave fetch,
  icache_mem_if.master  mem
`ifdef ICACHE_PERF_CNT_EN
  ,
  output logic [31:0]   hit_cnt_o,
  output logic [31:0]   miss_cnt_o
`endif
);

  icache_state_e    state_q, state_d;
  icache_addr_t     req_addr, miss_addr_q;
  logic [TAG_W-1:0] tag_q [NUM_SETS];
  logic [NUM_SETS-1:0] valid_q;
  logic [OFF_W-1:0] beat_q;
  logic             squash_q, inval_pend_q, hit_q;
  logic [31:0]      resp_word_q, ram_rdata;
  logic             idle, accept, lookup_hit, hit, miss;
  logic             fill_beat, last_beat, wipe;

  assign req_addr = fetch.icache_addr_i;
  assign idle     = (state_q == S_IDLE);

  // A flush or an invalidate in the same cycle drops the request entirely.
  assign accept     = idle && fetch.icache_en_i && !flush_i && !inval_i;
  assign lookup_hit = valid_q[req_addr.idx] && (tag_q[req_addr.idx] == req_addr.tag);
  assign hit        = accept && lookup_hit;
  assign miss       = accept && !lookup_hit;

  assign fill_beat = (state_q == S_FILL) && mem.mem_rvalid_i;
  assign last_beat = fill_beat && (beat_q == OFF_W'(LINE_WORDS - 1));

  // Invalidate applies immediately in IDLE; otherwise it is held until the FSM
  // heads back to IDLE, so the line being refilled is installed and then wiped.
  assign wipe = (idle && inval_i) ||
                (!idle && (state_d == S_IDLE) && (inval_pend_q || inval_i));

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (miss) state_d = S_MISS_REQ;
      S_MISS_REQ: if (mem.mem_gnt_i) state_d = S_FILL;
      S_FILL:     if (last_beat) state_d = (squash_q || flush_i) ? S_IDLE : S_RESP;
      S_RESP:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // ---------------- control state ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_q        <= 1'b0;
      miss_addr_q  <= '0;
      beat_q       <= '0;
      squash_q     <= 1'b0;
      inval_pend_q <= 1'b0;
      resp_word_q  <= '0;
      valid_q      <= '0;
    end else begin
      hit_q <= hit;

      if (miss) begin
        miss_addr_q <= req_addr;
        beat_q      <= '0;
        squash_q    <= 1'b0;
      end
      if ((state_q == S_MISS_REQ || state_q == S_FILL) && flush_i) squash_q <= 1'b1;

      // The requested word is captured in flight so RESP needs no extra RAM read.
      if (fill_beat) begin
        beat_q <= beat_q + 1'b1;
        if (beat_q == miss_addr_q.off) resp_word_q <= mem.mem_rdata_i;
      end

      if (wipe)                      inval_pend_q <= 1'b0;
      else if (!idle && inval_i)     inval_pend_q <= 1'b1;

      if (wipe)           valid_q <= '0;
      else if (last_beat) valid_q[miss_addr_q.idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (last_beat) tag_q[miss_addr_q.idx] <= miss_addr_q.tag;
  end

  icache_data_ram u_data_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (fill_beat),
    .waddr ({miss_addr_q.idx, beat_q}),
    .wdata (mem.mem_rdata_i),
    .re    (accept),
    .raddr ({req_addr.idx, req_addr.off}),
    .rdata (ram_rdata)
  );

  // ---------------- outputs ----------------
  assign fetch.icache_rvalid_o = hit_q || ((state_q == S_RESP) && !flush_i);
  assign fetch.icache_rdata_o  = (state_q == S_RESP) ? resp_word_q : ram_rdata;
  assign mem.mem_req_o         = (state_q == S_MISS_REQ);
  assign mem.mem_addr_o        = {miss_addr_q.tag, miss_addr_q.idx, {(OFF_W + 2){1'b0}}};

  logic unused_byte_off;
  assign unused_byte_off = ^{req_addr.byte_off, miss_addr_q.byte_off};

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit && (hit_cnt_q != 32'hFFFF_FFFF))   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`endif

endmodule

// File: tb/tb_icache_dm.sv
// tb_icache_dm: directed scoreboard bench for icache_dm.
// The driver pushes each expected response word; a negedge monitor pops and compares on every rvalid.
// Memory side is a simple in-line responder with programmable grant delay and beat data.
module tb_icache_dm;
  import icache_pkg::*;

  logic clk = 1'b0;
  logic rst_n, flush, inval;

  icache_fetch_if f();
  icache_mem_if   m();

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  icache_dm dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .inval_i (inval),
    .fetch   (f.slave),
    .mem     (m.master)
`ifdef ICACHE_PERF_CNT_EN
    ,
    .hit_cnt_o  (hit_cnt),
    .miss_cnt_o (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && f.icache_rvalid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rvalid actual=1 required=0 rdata=%h", f.icache_rdata_o);
      end else begin
        check("rdata", f.icache_rdata_o, exp_q.pop_front());
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] addr, input logic fl, input logic iv);
    f.icache_en_i   = 1'b1;
    f.icache_addr_i = addr;
    flush = fl;
    inval = iv;
    cycle();
    f.icache_en_i = 1'b0;
    flush = 1'b0;
    inval = 1'b0;
  endtask

  // Hit: expected word pushed, response must be visible the very next cycle with no memory request.
  task automatic hit_check(input logic [31:0] addr, input logic [31:0] exp);
    exp_q.push_back(exp);
    issue(addr, 1'b0, 1'b0);
    @(negedge clk);
    check("hit_latency", {31'd0, f.icache_rvalid_o}, 32'd1);
    check("hit_no_req", {31'd0, m.mem_req_o}, 32'd0);
    cycle();
  endtask

  // Serves one line refill; optional flush / invalidate on a given beat, or flush during RESP.
  task automatic serve_miss(input logic [31:0] line, input int gwait, input logic [31:0] base,
                            input int flush_beat, input int inval_beat, input logic flush_resp);
    int n;
    n = 0;
    while (m.mem_req_o !== 1'b1 && n < 8) begin
      cycle();
      n++;
    end
    check("miss_req", {31'd0, m.mem_req_o}, 32'd1);
    check("mem_addr", m.mem_addr_o, line);
    repeat (gwait) cycle();
    if (gwait > 0) check("req_held", {31'd0, m.mem_req_o}, 32'd1);
    m.mem_gnt_i = 1'b1;
    cycle();
    m.mem_gnt_i = 1'b0;
    for (int k = 0; k < int'(LINE_WORDS); k++) begin
      m.mem_rvalid_i = 1'b1;
      m.mem_rdata_i  = base + 32'(k);
      flush = (k == flush_beat);
      inval = (k == inval_beat);
      cycle();
    end
    m.mem_rvalid_i = 1'b0;
    flush = 1'b0;
    inval = 1'b0;
    if (flush_resp) begin
      flush = 1'b1;
      cycle();
      flush = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    inval = 1'b0;
    f.icache_en_i   = 1'b0;
    f.icache_addr_i = '0;
    m.mem_gnt_i     = 1'b0;
    m.mem_rvalid_i  = 1'b0;
    m.mem_rdata_i   = '0;

    repeat (3) cycle();
    @(negedge clk);
    check("rst_rvalid", {31'd0, f.icache_rvalid_o}, 32'd0);
    check("rst_rdata", f.icache_rdata_o, 32'd0);
    check("rst_mem_req", {31'd0, m.mem_req_o}, 32'd0);
    check("rst_mem_addr", m.mem_addr_o, 32'd0);
    cycle();
    rst_n = 1'b1;
    cycle();

    // 1. Cold miss, grant after 2 cycles.
    exp_q.push_back(32'hA0);
    issue(32'h100, 1'b0, 1'b0);
    serve_miss(32'h100, 2, 32'hA0, -1, -1, 1'b0);
    cycle();

    // 2. Hit on the freshly filled line.
    hit_check(32'h10C, 32'hA3);

    // 3. Conflict on the same set, then back again.
    exp_q.push_back(32'hB2);
    issue(32'h508, 1'b0, 1'b0);
    serve_miss(32'h500, 0, 32'hB0, -1, -1, 1'b0);
    cycle();
    exp_q.push_back(32'hC1);
    issue(32'h104, 1'b0, 1'b0);
    serve_miss(32'h100, 1, 32'hC0, -1, -1, 1'b0);
    cycle();
    hit_check(32'h100, 32'hC0);

    // 4. Flush during FILL: no response, but line is installed.
    issue(32'h200, 1'b0, 1'b0);
    serve_miss(32'h200, 0, 32'hD0, 1, -1, 1'b0);
    cycle();
    hit_check(32'h208, 32'hD2);

    // 5. en together with flush is dropped.
    issue(32'h300, 1'b1, 1'b0);
    cycle();
    check("flush_drop_req", {31'd0, m.mem_req_o}, 32'd0);
    cycle();

    // Flush during RESP suppresses rvalid; line still usable.
    issue(32'h400, 1'b0, 1'b0);
    serve_miss(32'h400, 0, 32'h50, -1, -1, 1'b1);
    cycle();
    hit_check(32'h40C, 32'h53);

    // 6. Invalidate in IDLE with en in the same cycle: en dropped, then a miss.
    issue(32'h100, 1'b0, 1'b1);
    check("inval_drop_req", {31'd0, m.mem_req_o}, 32'd0);
    cycle();
    exp_q.push_back(32'hA0);
    issue(32'h100, 1'b0, 1'b0);
    serve_miss(32'h100, 0, 32'hA0, -1, -1, 1'b0);
    cycle();

    // Deferred invalidate during FILL: response still delivered, line then cleared.
    exp_q.push_back(32'hE0);
    issue(32'h600, 1'b0, 1'b0);
    serve_miss(32'h600, 0, 32'hE0, -1, 0, 1'b0);
    cycle();
    exp_q.push_back(32'hF0);
    issue(32'h600, 1'b0, 1'b0);
    serve_miss(32'h600, 0, 32'hF0, -1, -1, 1'b0);
    cycle();

`ifdef ICACHE_PERF_CNT_EN
    check("hit_cnt", hit_cnt, 32'd4);
    check("miss_cnt", miss_cnt, 32'd8);
`endif

    // Reset in the middle of a refill; late beats must be ignored.
    issue(32'h700, 1'b0, 1'b0);
    m.mem_gnt_i = 1'b1;
    cycle();
    m.mem_gnt_i = 1'b0;
    m.mem_rvalid_i = 1'b1;
    m.mem_rdata_i  = 32'h77;
    cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    repeat (3) cycle();
    m.mem_rvalid_i = 1'b0;
    @(negedge clk);
    check("rst_mid_req", {31'd0, m.mem_req_o}, 32'd0);
    check("rst_mid_addr", m.mem_addr_o, 32'd0);
    check("rst_mid_rdata", f.icache_rdata_o, 32'd0);
    repeat (3) cycle();

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
